// File: rtl/sort_pkg.sv
// Shared definitions for the bubble-sort datapath and its input loader.
package sort_pkg;

   typedef enum logic [1:0] {
      FILL,
      WRITE,
      START,
      WAIT
   } sort_state_t;

   localparam int unsigned SORT_DATA_W    = 4;
   localparam int unsigned SORT_NUM_ELEMS = 4;

endpackage

// File: rtl/sort_input_loader_up_counter.sv
// Free-running up counter with synchronous clear (clear beats enable).
module up_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sort_input_loader.sv
// Buffers one batch of elements from a valid/ready stream, replays it to the
// sorter as back-to-back writes, pulses sort_start and waits for sort_done.
module sort_input_loader
   import sort_pkg::*;
#(
   parameter int unsigned DATA_W    = SORT_DATA_W,
   parameter int unsigned NUM_ELEMS = SORT_NUM_ELEMS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [DATA_W-1:0] writedata,
   output logic              write,
   output logic              sort_start,
   input  logic              sort_done,
   output logic              busy,
   output logic [7:0]        batch_count
);

   localparam int unsigned      CNT_W     = $clog2(NUM_ELEMS + 1);
   localparam int unsigned      IDX_W     = $clog2(NUM_ELEMS);
   localparam logic [CNT_W-1:0] FULL      = CNT_W'(NUM_ELEMS);
   localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(NUM_ELEMS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ELEMS - 1);

   sort_state_t       state;
   logic [DATA_W-1:0] buffer [NUM_ELEMS];
   logic [CNT_W-1:0]  fill_cnt;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_nxt;
   logic [IDX_W-1:0]  fill_idx;
   logic              accept;
   logic              fill_clr;
   logic              in_fill;
   logic              in_write;
   logic              in_start;

   assign in_fill  = (state == FILL);
   assign in_write = (state == WRITE);
   assign in_start = (state == START);
   assign in_ready = in_fill && (fill_cnt < FULL);
   // flush wins over a simultaneous transfer, so the element is dropped
   assign accept   = in_valid && in_ready && !flush;
   assign fill_clr = (in_fill && flush) || ((state == WAIT) && sort_done);
   assign fill_idx = fill_cnt[IDX_W-1:0];
   assign idx_nxt  = idx + 1'b1;

   up_counter #(.WIDTH(CNT_W)) u_fill_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fill_clr),
      .en    (accept),
      .count (fill_cnt)
   );

   up_counter #(.WIDTH(IDX_W)) u_replay_idx (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!in_write),
      .en    (in_write),
      .count (idx)
   );

   up_counter #(.WIDTH(8)) u_batch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .en    (in_start),
      .count (batch_count)
   );

   // writedata is prefetched one element ahead so writes run back-to-back
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= FILL;
         write      <= 1'b0;
         sort_start <= 1'b0;
         writedata  <= '0;
         busy       <= 1'b0;
         for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
            buffer[i] <= '0;
         end
      end else begin
         if (accept) begin
            buffer[fill_idx] <= in_data;
         end
         unique case (state)
            FILL: begin
               if (accept && (fill_cnt == LAST_FILL)) begin
                  state     <= WRITE;
                  write     <= 1'b1;
                  busy      <= 1'b1;
                  writedata <= buffer[0];
               end
            end
            WRITE: begin
               if (idx == LAST_IDX) begin
                  state      <= START;
                  write      <= 1'b0;
                  sort_start <= 1'b1;
               end else begin
                  writedata <= buffer[idx_nxt];
               end
            end
            START: begin
               state      <= WAIT;
               sort_start <= 1'b0;
            end
            WAIT: begin
               if (sort_done) begin
                  state <= FILL;
                  busy  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sort_input_loader.sv
// Directed bench for sort_input_loader with hand-computed expectations.
module tb_sort_input_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       flush;
   logic [3:0] writedata;
   logic       write;
   logic       sort_start;
   logic       sort_done;
   logic       busy;
   logic [7:0] batch_count;

   int unsigned pass_cnt = 0;
   int unsigned fail_cnt = 0;
   int unsigned total_cnt = 0;

   sort_input_loader #(.DATA_W(4), .NUM_ELEMS(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .writedata   (writedata),
      .write       (write),
      .sort_start  (sort_start),
      .sort_done   (sort_done),
      .busy        (busy),
      .batch_count (batch_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic feed(input logic [3:0] v);
      in_valid = 1'b1;
      in_data  = v;
      chk("in_ready_fill", 8'(in_ready), 8'd1);
      tick();
   endtask

   // Called in the first write cycle; returns in the first WAIT cycle.
   task automatic replay(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input logic [7:0] bc_before, input int done_at);
      logic [3:0] v [4];
      logic [7:0] bc_after;
      v = '{a, b, c, d};
      bc_after = bc_before + 8'd1;
      for (int k = 0; k < 4; k++) begin
         sort_done = (k == done_at);
         chk("write", 8'(write), 8'd1);
         chk("writedata", 8'(writedata), 8'(v[k]));
         chk("in_ready_write", 8'(in_ready), 8'd0);
         chk("busy_write", 8'(busy), 8'd1);
         tick();
      end
      sort_done = 1'b0;
      chk("sort_start", 8'(sort_start), 8'd1);
      chk("write_in_start", 8'(write), 8'd0);
      chk("batch_count_start", batch_count, bc_before);
      tick();
      chk("sort_start_low", 8'(sort_start), 8'd0);
      chk("batch_count_after", batch_count, bc_after);
      chk("busy_wait", 8'(busy), 8'd1);
   endtask

   task automatic release_wait();
      sort_done = 1'b1;
      tick();
      sort_done = 1'b0;
      chk("in_ready_after_done", 8'(in_ready), 8'd1);
      chk("busy_after_done", 8'(busy), 8'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = 4'h0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      sort_done = 1'b0;
      tick();
      tick();
      chk("rst_write", 8'(write), 8'd0);
      chk("rst_sort_start", 8'(sort_start), 8'd0);
      chk("rst_writedata", 8'(writedata), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_batch_count", batch_count, 8'd0);
      rst_n = 1'b1;
      chk("rst_in_ready", 8'(in_ready), 8'd1);

      // Batch with in_valid held; excess element E waits through WAIT
      feed(4'h3);
      feed(4'h9);
      feed(4'h1);
      feed(4'h7);
      in_data = 4'hE;
      replay(4'h3, 4'h9, 4'h1, 4'h7, 8'd0, -1);
      chk("in_ready_wait0", 8'(in_ready), 8'd0);
      tick();
      chk("in_ready_wait1", 8'(in_ready), 8'd0);
      release_wait();
      feed(4'hE);
      feed(4'h2);
      feed(4'h5);
      feed(4'h6);
      in_valid = 1'b0;
      // sort_done during WRITE must be ignored
      replay(4'hE, 4'h2, 4'h5, 4'h6, 8'd1, 2);
      chk("ignored_done_ready", 8'(in_ready), 8'd0);
      tick();
      chk("ignored_done_ready2", 8'(in_ready), 8'd0);
      chk("ignored_done_busy", 8'(busy), 8'd1);
      release_wait();

      // Gapped input still yields back-to-back writes
      feed(4'hA);
      in_valid = 1'b0; in_data = 4'h7;
      tick();
      feed(4'h0);
      in_valid = 1'b0; in_data = 4'h7;
      tick();
      tick();
      feed(4'hF);
      in_valid = 1'b0; in_data = 4'h7;
      tick();
      feed(4'h5);
      in_valid = 1'b0;
      replay(4'hA, 4'h0, 4'hF, 4'h5, 8'd2, -1);
      release_wait();

      // Flush discards partial batch; simultaneous element dropped
      feed(4'hB);
      feed(4'hC);
      flush = 1'b1; in_valid = 1'b1; in_data = 4'hD;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("in_ready_after_flush", 8'(in_ready), 8'd1);
      feed(4'h4);
      feed(4'h4);
      feed(4'h2);
      feed(4'h8);
      in_valid = 1'b0;
      replay(4'h4, 4'h4, 4'h2, 4'h8, 8'd3, -1);
      release_wait();

      // Reset during the second write cycle
      feed(4'h9);
      feed(4'h9);
      feed(4'h9);
      feed(4'h9);
      in_valid = 1'b0;
      chk("pre_rst_write0", 8'(write), 8'd1);
      tick();
      chk("pre_rst_write1", 8'(write), 8'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_write", 8'(write), 8'd0);
      chk("midrst_sort_start", 8'(sort_start), 8'd0);
      chk("midrst_busy", 8'(busy), 8'd0);
      chk("midrst_batch_count", batch_count, 8'd0);
      chk("midrst_in_ready", 8'(in_ready), 8'd1);
      chk("midrst_writedata", 8'(writedata), 8'd0);
      feed(4'h1);
      feed(4'h2);
      feed(4'h3);
      feed(4'h4);
      in_valid = 1'b0;
      replay(4'h1, 4'h2, 4'h3, 4'h4, 8'd0, -1);
      release_wait();

      // Drive batch_count up to 255, then check the wrap
      for (int unsigned b = 0; b < 254; b++) begin
         feed(4'(b));
         feed(4'(b + 1));
         feed(4'(b + 2));
         feed(4'(b + 3));
         in_valid = 1'b0;
         repeat (5) tick();
         sort_done = 1'b1;
         tick();
         sort_done = 1'b0;
      end
      chk("batch_count_255", batch_count, 8'd255);
      feed(4'h5);
      feed(4'h6);
      feed(4'h7);
      feed(4'h8);
      in_valid = 1'b0;
      replay(4'h5, 4'h6, 4'h7, 4'h8, 8'd255, -1);
      chk("batch_count_wrap", batch_count, 8'd0);
      release_wait();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
